// File: rtl/link_pkg.sv
// Shared definitions for the link receiver: peer protocol state encodings
// and synchronizer depth.
package link_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONN = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } peer_state_t;

    localparam int unsigned SYNC_DEPTH = 2;

endpackage

// File: rtl/link_filter.sv
// One receive channel: 2-flop synchronizer, stability-count filter and
// registered rising-edge pulse aligned with the filtered level.
module link_filter
    import link_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam logic [7:0] LAST = 8'(FILTER_LEN - 1);

    logic [SYNC_DEPTH-1:0] sync_q;
    logic [7:0]            cnt;
    logic                  synced;

    assign synced = sync_q[SYNC_DEPTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt    <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], raw};
            rise   <= 1'b0;
            if (synced == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                // Accept on the edge the count would reach FILTER_LEN.
                level <= synced;
                rise  <= synced;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/link_receiver.sv
// Peer link receiver: three filtered channels plus peer protocol FSM.
// Optional sticky protocol checking is enabled by LINK_RX_ERR_CHECK_EN.
module link_receiver
    import link_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       receive_connect,
    input  logic       receive_start,
    input  logic       receive_game_finish,
    output logic       peer_connect,
    output logic       peer_start,
    output logic       peer_finish,
    output logic       connect_rise,
    output logic       start_rise,
    output logic       finish_rise,
    output logic [1:0] peer_state,
    output logic       link_err
);

    peer_state_t state;

    link_filter #(.FILTER_LEN(FILTER_LEN)) u_connect (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (receive_connect),
        .level (peer_connect),
        .rise  (connect_rise)
    );

    link_filter #(.FILTER_LEN(FILTER_LEN)) u_start (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (receive_start),
        .level (peer_start),
        .rise  (start_rise)
    );

    link_filter #(.FILTER_LEN(FILTER_LEN)) u_finish (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (receive_game_finish),
        .level (peer_finish),
        .rise  (finish_rise)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (state == IDLE) begin
            if (peer_connect) state <= CONN;
        end else if (!peer_connect) begin
            // Losing connect overrides every other transition.
            state <= IDLE;
        end else begin
            unique case (state)
                CONN:    if (peer_start) state <= RUN;
                RUN:     if (peer_finish) state <= DONE;
                DONE:    if (!peer_start && !peer_finish) state <= CONN;
                default: state <= IDLE;
            endcase
        end
    end

    assign peer_state = state;

`ifdef LINK_RX_ERR_CHECK_EN
    logic err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if ((start_rise && state == IDLE) ||
                     (finish_rise && (state == IDLE || state == CONN))) begin
            err <= 1'b1;
        end
    end

    assign link_err = err;
`else
    assign link_err = 1'b0;
`endif

endmodule

// File: tb/tb_link_receiver.sv
// Directed self-checking bench for link_receiver with FILTER_LEN=4.
module tb_link_receiver;
    import link_pkg::*;

`ifdef LINK_RX_ERR_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       receive_connect;
    logic       receive_start;
    logic       receive_game_finish;
    logic       peer_connect;
    logic       peer_start;
    logic       peer_finish;
    logic       connect_rise;
    logic       start_rise;
    logic       finish_rise;
    logic [1:0] peer_state;
    logic       link_err;

    int vectors;
    int miscompares;

    link_receiver #(.FILTER_LEN(4)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .receive_connect     (receive_connect),
        .receive_start       (receive_start),
        .receive_game_finish (receive_game_finish),
        .peer_connect        (peer_connect),
        .peer_start          (peer_start),
        .peer_finish         (peer_finish),
        .connect_rise        (connect_rise),
        .start_rise          (start_rise),
        .finish_rise         (finish_rise),
        .peer_state          (peer_state),
        .link_err            (link_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_clear(input string tag);
        check_bit({tag, "_connect"}, peer_connect, 1'b0);
        check_bit({tag, "_start"}, peer_start, 1'b0);
        check_bit({tag, "_finish"}, peer_finish, 1'b0);
        check_bit({tag, "_rises"}, connect_rise | start_rise | finish_rise, 1'b0);
        check_state({tag, "_state"}, peer_state, 2'd0);
        check_bit({tag, "_err"}, link_err, 1'b0);
    endtask

    initial begin
        vectors             = 0;
        miscompares         = 0;
        rst_n               = 1'b0;
        receive_connect     = 1'b0;
        receive_start       = 1'b0;
        receive_game_finish = 1'b0;

        // Reset state and quiet first release cycle
        tick(3);
        check_all_clear("reset");
        rst_n = 1'b1;
        tick(1);
        check_all_clear("release");

        // Connect latency: 2 + FILTER_LEN = 6 cycles, state one cycle later
        receive_connect = 1'b1;
        tick(5);
        check_bit("conn_early", peer_connect, 1'b0);
        tick(1);
        check_bit("conn_level", peer_connect, 1'b1);
        check_bit("conn_rise", connect_rise, 1'b1);
        check_state("conn_state_lag", peer_state, 2'd0);
        tick(1);
        check_bit("conn_rise_1cyc", connect_rise, 1'b0);
        check_state("conn_state", peer_state, 2'd1);

        // Start glitch of 3 cycles is rejected
        receive_start = 1'b1;
        tick(3);
        receive_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_bit("glitch_level", peer_start, 1'b0);
            check_bit("glitch_rise", start_rise, 1'b0);
            tick(1);
        end
        check_state("glitch_state", peer_state, 2'd1);

        // CONN -> RUN -> DONE -> CONN
        receive_start = 1'b1;
        tick(6);
        check_bit("start_level", peer_start, 1'b1);
        check_bit("start_rise", start_rise, 1'b1);
        tick(1);
        check_state("run_state", peer_state, 2'd2);
        receive_game_finish = 1'b1;
        tick(6);
        check_bit("finish_level", peer_finish, 1'b1);
        check_bit("finish_rise", finish_rise, 1'b1);
        check_state("finish_state_lag", peer_state, 2'd2);
        tick(1);
        check_state("done_state", peer_state, 2'd3);
        receive_start       = 1'b0;
        receive_game_finish = 1'b0;
        tick(6);
        check_bit("fall_no_rise", start_rise | finish_rise, 1'b0);
        check_bit("start_fell", peer_start, 1'b0);
        check_state("done_hold", peer_state, 2'd3);
        tick(1);
        check_state("back_to_conn", peer_state, 2'd1);

        // In RUN, connect drop and finish rise together -> IDLE wins
        receive_start = 1'b1;
        tick(7);
        check_state("run_again", peer_state, 2'd2);
        receive_connect     = 1'b0;
        receive_game_finish = 1'b1;
        tick(6);
        check_bit("drop_connect", peer_connect, 1'b0);
        check_bit("drop_finish", peer_finish, 1'b1);
        tick(1);
        check_state("drop_to_idle", peer_state, 2'd0);
        tick(1);
        check_state("idle_hold", peer_state, 2'd0);
        check_bit("err_none", link_err, 1'b0);

        // Start rising in IDLE: protocol error when checking is enabled
        receive_start       = 1'b0;
        receive_game_finish = 1'b0;
        tick(8);
        receive_start = 1'b1;
        tick(6);
        check_bit("idle_start_rise", start_rise, 1'b1);
        check_state("idle_start_state", peer_state, 2'd0);
        tick(1);
        check_bit("err_set", link_err, EXP_ERR);
        receive_connect = 1'b1;
        tick(6);
        check_bit("err_conn_rise", connect_rise, 1'b1);
        tick(2);
        check_state("err_seq_run", peer_state, 2'd2);
        check_bit("err_sticky", link_err, EXP_ERR);

        // Reset mid-filter discards count; latency restarts after release
        receive_connect = 1'b0;
        receive_start   = 1'b0;
        rst_n           = 1'b0;
        #2;
        check_all_clear("reset2");
        tick(1);
        rst_n = 1'b1;
        tick(3);
        receive_connect = 1'b1;
        tick(2);
        rst_n = 1'b0;
        #1;
        check_all_clear("mid_reset");
        tick(2);
        check_all_clear("mid_reset_hold");
        rst_n = 1'b1;
        tick(1);
        check_bit("rel_quiet", peer_connect, 1'b0);
        tick(4);
        check_bit("rel_early", peer_connect, 1'b0);
        tick(1);
        check_bit("rel_level", peer_connect, 1'b1);
        check_bit("rel_rise", connect_rise, 1'b1);
        tick(1);
        check_state("rel_state", peer_state, 2'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/link_receiver.md
LINK_RECEIVER -- requirements
Module: link_receiver

Interface
REQ-001 Parameter FILTER_LEN, default 4, number of consecutive stable synchronized cycles required to accept a level change; legal range 1..255.
REQ-002 clk  input  1  sole clock, all flops on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 receive_connect  input  1  raw peer connect wire, asynchronous to clk.
REQ-005 receive_start  input  1  raw peer start wire, asynchronous to clk.
REQ-006 receive_game_finish  input  1  raw peer finish wire, asynchronous to clk.
REQ-007 peer_connect  output  1  filtered connect level.
REQ-008 peer_start  output  1  filtered start level.
REQ-009 peer_finish  output  1  filtered finish level.
REQ-010 connect_rise  output  1  one-cycle pulse on peer_connect 0->1.
REQ-011 start_rise  output  1  one-cycle pulse on peer_start 0->1.
REQ-012 finish_rise  output  1  one-cycle pulse on peer_finish 0->1.
REQ-013 peer_state  output  2  peer protocol state: 0 IDLE, 1 CONN, 2 RUN, 3 DONE.
REQ-014 link_err  output  1  sticky protocol-violation flag (see Configuration).

Function
REQ-015 Each raw input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-016 Per channel, a counter SHALL increment each cycle the synchronized value differs from the filtered level and clear on any agreeing cycle.
REQ-017 Filtered level SHALL take the synchronized value on the edge the counter would reach FILTER_LEN; counter then clears.
REQ-018 Latency from a clean raw edge (held stable) to filtered level change SHALL be exactly 2+FILTER_LEN cycles.
REQ-019 A raw pulse shorter than FILTER_LEN synchronized cycles SHALL produce no filtered change and no rise pulse.
REQ-020 Rise pulses SHALL be high in the same cycle the filtered level first reads 1, for exactly one cycle; falls produce no pulse.
REQ-021 State machine, evaluated on filtered levels, one transition per cycle maximum:
 - IDLE -> CONN when peer_connect=1.
 - CONN -> RUN when peer_start=1.
 - RUN -> DONE when peer_finish=1.
 - DONE -> CONN when peer_start=0 and peer_finish=0.
 - any non-IDLE -> IDLE when peer_connect=0; this dominates all other conditions in the same cycle.
REQ-022 Connect and start rising in the same cycle from IDLE SHALL yield CONN that cycle and RUN the following cycle.
REQ-023 peer_state SHALL be a registered output, updating one cycle after the filtered levels that cause the transition.

Reset
REQ-024 rst_n low SHALL immediately clear synchronizers, counters, filtered levels, rise pulses, link_err, and set peer_state to IDLE.
REQ-025 Reset asserted mid-filter SHALL discard the partial count; after release the 2+FILTER_LEN latency restarts from the first sampled edge.
REQ-026 Release of rst_n SHALL be usable asynchronously; no output toggles in the first release cycle.

Configuration
REQ-027 Macro LINK_RX_ERR_CHECK_EN: when defined, link_err SHALL set and stay set until reset on start_rise in IDLE, or on finish_rise in IDLE or CONN.
REQ-028 Without LINK_RX_ERR_CHECK_EN, link_err SHALL be tied to 0 and no checking logic is synthesized; all other behaviour is unchanged.

Structure
REQ-029 Shared package link_pkg SHALL hold the peer_state encodings (IDLE, CONN, RUN, DONE) and the synchronizer depth constant (2).
REQ-030 Sub-module link_filter (synchronizer + stability counter + rise detect, one channel) SHALL be instantiated three times.

Verification
REQ-031 FILTER_LEN=4, raw connect 0->1 held -> peer_connect=1 and connect_rise pulse exactly 6 cycles later; peer_state=CONN 1 cycle after that.
REQ-032 Raw start glitch high for 3 cycles -> peer_start stays 0, no start_rise, state unchanged.
REQ-033 Sequence connect, start, finish each held -> states IDLE->CONN->RUN->DONE; start and finish dropped -> CONN.
REQ-034 In RUN, drop connect while finish rises in the same filtered cycle -> state goes to IDLE, not DONE.
REQ-035 LINK_RX_ERR_CHECK_EN defined, start asserted with connect low -> link_err=1 and holds through later normal sequence until rst_n low.
REQ-036 rst_n pulsed low 2 cycles after a raw connect edge -> all outputs 0/IDLE; connect still high after release -> peer_connect rises 6 cycles after release.
